// File: rtl/exec_pkg.sv
// Shared opcode map and FSM state encoding for the execute stage.
package exec_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_ADDI  = 4'd8;
  localparam logic [3:0] OP_MOV   = 4'd9;
  localparam logic [3:0] OP_AUIPC = 4'd10;

  // Opcodes above AUIPC are reserved and flagged as illegal.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_AUIPC);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: result, zero flag, signed-overflow flag and illegal-opcode flag.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_ovf,
  output logic              o_err
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_add_x;
  logic [DATA_W-1:0] w_add_y;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_add_ovf;
  logic              w_sub_ovf;

  assign w_sh = i_b[SH_W-1:0];

  // One shared adder serves ADD, ADDI and AUIPC.
  always_comb begin
    w_add_x = i_a;
    w_add_y = i_b;
    case (i_op)
      OP_ADDI: begin
        w_add_x = i_a;
        w_add_y = i_imm;
      end
      OP_AUIPC: begin
        w_add_x = i_pc;
        w_add_y = i_imm;
      end
      default: begin
        w_add_x = i_a;
        w_add_y = i_b;
      end
    endcase
  end

  assign w_sum     = w_add_x + w_add_y;
  assign w_diff    = i_a - i_b;
  assign w_add_ovf = (w_add_x[DATA_W-1] == w_add_y[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != w_add_x[DATA_W-1]);
  assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != i_a[DATA_W-1]);

  // Operation select and overflow attribution.
  always_comb begin
    o_result = {DATA_W{1'b0}};
    o_ovf    = 1'b0;
    case (i_op)
      OP_ADD, OP_ADDI, OP_AUIPC: begin
        o_result = w_sum;
        o_ovf    = w_add_ovf;
      end
      OP_SUB: begin
        o_result = w_diff;
        o_ovf    = w_sub_ovf;
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLL:  o_result = i_a << w_sh;
      OP_SRL:  o_result = i_a >> w_sh;
      OP_SRA:  o_result = DATA_W'($signed(i_a) >>> w_sh);
      OP_MOV:  o_result = i_a;
      default: begin
        o_result = {DATA_W{1'b0}};
        o_ovf    = 1'b0;
      end
    endcase
  end

  assign o_err  = ~op_is_legal(i_op);
  assign o_zero = (o_result == {DATA_W{1'b0}});

endmodule

// File: rtl/exec_stage.sv
// Multi-cycle execute stage: IDLE -> DECODE -> EXEC -> DONE with a local register file.
module exec_stage
  import exec_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int REG_AW  = 4,
  parameter  int R0_ZERO = 0,
  localparam int INSTR_W = 4 + 3*REG_AW,
  localparam int IMM_W   = 2*REG_AW
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic [REG_AW-1:0]  rd_out,
  output logic               zero,
  output logic               ovf,
  output logic               err,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int NREG = 1 << REG_AW;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_result;
  logic [REG_AW-1:0]  r_rd;
  logic               r_zero;
  logic               r_ovf;
  logic               r_err;
  logic [DATA_W-1:0]  r_rf [NREG];

  logic [3:0]         w_op;
  logic [REG_AW-1:0]  w_rd;
  logic [REG_AW-1:0]  w_rs0;
  logic [REG_AW-1:0]  w_rs1;
  logic [REG_AW-1:0]  w_a_addr;
  logic [IMM_W-1:0]   w_imm_raw;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_alu_result;
  logic               w_alu_zero;
  logic               w_alu_ovf;
  logic               w_alu_err;
  logic               w_wb_en;

  assign w_op      = r_instr[INSTR_W-1 -: 4];
  assign w_rd      = r_instr[3*REG_AW-1 -: REG_AW];
  assign w_rs0     = r_instr[2*REG_AW-1 -: REG_AW];
  assign w_rs1     = r_instr[REG_AW-1:0];
  assign w_imm_raw = {w_rs0, w_rs1};
  assign w_imm     = DATA_W'($signed(w_imm_raw));
  // ADDI accumulates into its own destination, so operand A comes from rd.
  assign w_a_addr  = (w_op == OP_ADDI) ? w_rd : w_rs0;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign rd_out    = r_rd;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign err       = r_err;

  // Register 0 is never written when R0_ZERO is set, so it keeps its reset value of 0.
  assign w_wb_en  = (r_state == ST_DONE) && out_ready && !r_err &&
                    !((R0_ZERO != 0) && (r_rd == {REG_AW{1'b0}}));
  assign dbg_data = r_rf[dbg_addr];

  exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (w_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_pc     (r_pc),
    .i_imm    (w_imm),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero),
    .o_ovf    (w_alu_ovf),
    .o_err    (w_alu_err)
  );

  // Next-state logic for the four-phase handshake FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC:   w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture, operand fetch and result registers; outputs hold while DONE stalls.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_instr  <= {INSTR_W{1'b0}};
      r_pc     <= {DATA_W{1'b0}};
      r_a      <= {DATA_W{1'b0}};
      r_b      <= {DATA_W{1'b0}};
      r_result <= {DATA_W{1'b0}};
      r_rd     <= {REG_AW{1'b0}};
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && in_valid) begin
        r_instr <= instr;
        r_pc    <= pc_in;
      end
      if (r_state == ST_DECODE) begin
        r_a <= r_rf[w_a_addr];
        r_b <= r_rf[w_rs1];
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_alu_result;
        r_rd     <= w_rd;
        r_zero   <= w_alu_zero;
        r_ovf    <= w_alu_ovf;
        r_err    <= w_alu_err;
      end
    end
  end

  // Register file: asynchronous read above, synchronous writeback on the DONE handshake.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wb_en) begin
      r_rf[r_rd] <= r_result;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: vector table with scoreboard plus stall/reset sequences.
module tb_exec_stage;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  rd;
    logic        zero;
    logic        ovf;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    exp_t        exp;
  } vec_t;

  logic        CLK;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  rd_out;
  logic        zero;
  logic        ovf;
  logic        err;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [15:0] mdl_rf [16];
  vec_t vecs [21];

  exec_stage #(.DATA_W(16), .REG_AW(4), .R0_ZERO(0)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: pop one expected record per output handshake.
  always @(negedge CLK) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", result, mon_e.result);
        chk("rd_out", rd_out, mon_e.rd);
        chk("zero",   zero,   mon_e.zero);
        chk("ovf",    ovf,    mon_e.ovf);
        chk("err",    err,    mon_e.err);
      end
    end
  end

  // Entered at posedge+2; returns at the negedge of the first DONE cycle.
  task automatic issue(input logic [15:0] ins, input logic [15:0] pc, input exp_t e);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge CLK); #2;
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    instr    = ins;
    pc_in    = pc;
    @(posedge CLK);
    sb_q.push_back(e);
    #2;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk("latency_out_valid", out_valid, (k == 3));
    end
  endtask

  task automatic sweep_rf(input string name);
    for (int a = 0; a < 16; a++) begin
      dbg_addr = 4'(a);
      #1;
      chk(name, dbg_data, mdl_rf[a]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{16'h8105, 16'h0000, '{16'h0005, 4'd1,  1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{16'h0211, 16'h0000, '{16'h000A, 4'd2,  1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{16'h5311, 16'h0000, '{16'h00A0, 4'd3,  1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{16'h8601, 16'h0000, '{16'h0001, 4'd6,  1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{16'h870F, 16'h0000, '{16'h000F, 4'd7,  1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{16'h5167, 16'h0000, '{16'h8000, 4'd1,  1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{16'h82FA, 16'h0000, '{16'h0004, 4'd2,  1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{16'h7812, 16'h0000, '{16'hF800, 4'd8,  1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{16'h0911, 16'h0000, '{16'h0000, 4'd9,  1'b1, 1'b1, 1'b0}};
    vecs[9]  = '{16'h1A21, 16'h0000, '{16'h8004, 4'd10, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{16'h2B12, 16'h0000, '{16'h0000, 4'd11, 1'b1, 1'b0, 1'b0}};
    vecs[11] = '{16'h3C12, 16'h0000, '{16'h8004, 4'd12, 1'b0, 1'b0, 1'b0}};
    vecs[12] = '{16'h4D11, 16'h0000, '{16'h0000, 4'd13, 1'b1, 1'b0, 1'b0}};
    vecs[13] = '{16'h6E12, 16'h0000, '{16'h0800, 4'd14, 1'b0, 1'b0, 1'b0}};
    vecs[14] = '{16'hA5FE, 16'h0100, '{16'h00FE, 4'd5,  1'b0, 1'b0, 1'b0}};
    vecs[15] = '{16'h9F50, 16'h0000, '{16'h00FE, 4'd15, 1'b0, 1'b0, 1'b0}};
    vecs[16] = '{16'h8CFB, 16'h0000, '{16'h7FFF, 4'd12, 1'b0, 1'b1, 1'b0}};
    vecs[17] = '{16'h5D6C, 16'h0000, '{16'h8000, 4'd13, 1'b0, 1'b0, 1'b0}};
    vecs[18] = '{16'hA401, 16'h7FFF, '{16'h8000, 4'd4,  1'b0, 1'b1, 1'b0}};
    vecs[19] = '{16'hF123, 16'h0000, '{16'h0000, 4'd1,  1'b1, 1'b0, 1'b1}};
    vecs[20] = '{16'hB0FF, 16'h0000, '{16'h0000, 4'd0,  1'b1, 1'b0, 1'b1}};
    for (int i = 0; i < 16; i++) mdl_rf[i] = 16'h0000;

    reset     = 1'b1;
    in_valid  = 1'b0;
    instr     = 16'h0000;
    pc_in     = 16'h0000;
    out_ready = 1'b1;
    dbg_addr  = 4'd0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result",    result,    16'h0000);
    chk("rst_err",       err,       1'b0);
    sweep_rf("rst_rf");
    @(posedge CLK); @(posedge CLK); #2;
    reset = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge CLK); #2;

    for (int i = 0; i < 21; i++) begin
      issue(vecs[i].instr, vecs[i].pc, vecs[i].exp);
      @(posedge CLK); #2;
      if (!vecs[i].exp.err) mdl_rf[vecs[i].exp.rd] = vecs[i].exp.result;
    end
    sweep_rf("rf_after_table");

    // Stall in DONE for four cycles, then release; writeback lands exactly once.
    out_ready = 1'b0;
    dbg_addr  = 4'd3;
    issue(16'h8301, 16'h0000, '{16'h00A1, 4'd3, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready",  in_ready,  1'b0);
      chk("stall_result",    result,    16'h00A1);
      chk("stall_rd_out",    rd_out,    4'd3);
      chk("stall_no_wb",     dbg_data,  mdl_rf[3]);
    end
    @(posedge CLK); #2;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("dbg_old_on_wb", dbg_data, 16'h00A0);
    @(posedge CLK); #2;
    mdl_rf[3] = 16'h00A1;
    chk("post_wb_out_valid", out_valid, 1'b0);
    chk("post_wb_in_ready",  in_ready,  1'b1);
    chk("post_wb_rf",        dbg_data,  mdl_rf[3]);
    @(posedge CLK); #2;
    chk("single_wb_rf", dbg_data, mdl_rf[3]);

    // Reset asserted while an instruction sits in EXEC.
    in_valid = 1'b1;
    instr    = 16'h8301;
    @(posedge CLK); #2;
    in_valid = 1'b0;
    @(posedge CLK); #2;
    reset = 1'b1;
    #1;
    chk("exec_rst_out_valid", out_valid, 1'b0);
    chk("exec_rst_result",    result,    16'h0000);
    chk("exec_rst_rd_out",    rd_out,    4'd0);
    chk("exec_rst_flags",     {zero, ovf, err}, 3'b000);
    for (int i = 0; i < 16; i++) mdl_rf[i] = 16'h0000;
    sweep_rf("exec_rst_rf");
    @(posedge CLK); #2;
    reset = 1'b0;
    @(negedge CLK);
    chk("exec_rst_in_ready", in_ready, 1'b1);
    chk("exec_rst_no_out",   out_valid, 1'b0);
    @(posedge CLK); #2;
    issue(16'h8105, 16'h0000, '{16'h0005, 4'd1, 1'b0, 1'b0, 1'b0});
    @(posedge CLK); #2;
    mdl_rf[1] = 16'h0005;
    sweep_rf("rf_after_reset_run");

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath and register width; legal range 8..64.
REQ-002 SHALL have parameter REG_AW, default 4: register-address width, giving 2**REG_AW registers.
REQ-003 SHALL have parameter R0_ZERO, default 0: when 1, register 0 reads 0 and ignores writes.
REQ-004 SHALL derive INSTR_W = 4 + 3*REG_AW and IMM_W = 2*REG_AW.
REQ-005 SHALL have port CLK, input, 1: rising-edge clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: instr and pc_in are valid.
REQ-008 SHALL have port in_ready, output, 1: stage accepts an instruction.
REQ-009 SHALL have port instr, input, INSTR_W: fields are {opcode[3:0], rd, rs0, rs1}, MSB first.
REQ-010 SHALL have port pc_in, input, DATA_W: PC of the instruction.
REQ-011 SHALL have port out_valid, output, 1: result fields are valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port result, output, DATA_W: ALU result.
REQ-014 SHALL have port rd_out, output, REG_AW: destination register.
REQ-015 SHALL have port zero, output, 1: result == 0.
REQ-016 SHALL have port ovf, output, 1: signed overflow on ADD, SUB, ADDI or AUIPC; 0 for all other opcodes.
REQ-017 SHALL have port err, output, 1: illegal opcode.
REQ-018 SHALL have port dbg_addr, input, REG_AW: debug read address.
REQ-019 SHALL have port dbg_data, output, DATA_W: combinational read of the register at dbg_addr.

Function
REQ-020 SHALL implement a four-state FSM: IDLE, DECODE, EXEC, DONE.
REQ-021 SHALL assert in_ready only in IDLE.
REQ-022 SHALL, on in_valid && in_ready, capture instr and pc_in into internal registers and go to DECODE.
REQ-023 SHALL, in DECODE, latch A = RF[rs0] and B = RF[rs1], then go to EXEC.
REQ-024 SHALL, in EXEC, register result, zero, ovf, err and rd_out, then go to DONE.
REQ-025 SHALL assert out_valid only in DONE and hold all output fields stable while out_ready is low.
REQ-026 SHALL, in DONE with out_ready high, write result to RF[rd] (skipped if err), then go to IDLE; accept-to-out_valid latency is 3 cycles, and the next accept is no earlier than 1 cycle after the handshake.
REQ-027 SHALL implement opcodes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, and 7 SRA, computing A op B.
REQ-028 SHALL implement opcode 8 ADDI: A = RF[rd], result = A + sext({rs0,rs1}).
REQ-029 SHALL implement opcode 9 MOV: result = A.
REQ-030 SHALL implement opcode 10 AUIPC: result = pc_in + sext({rs0,rs1}).
REQ-031 SHALL treat opcodes 11..15 as illegal: err=1, result=0, no register write.
REQ-032 SHALL use B[$clog2(DATA_W)-1:0] as the shift amount and ignore the upper bits of B.
REQ-033 SHALL perform all arithmetic modulo 2**DATA_W.
REQ-034 SHALL, when the DONE writeback targets a register that is also being read by dbg_data, drive dbg_data with the old value in that cycle.

Reset
REQ-035 SHALL, on reset assertion in any state, immediately enter IDLE, clear all register-file entries and internal registers to 0, and drive out_valid=0, result=0, rd_out=0, zero=0, ovf=0, err=0.
REQ-036 SHALL abandon any in-flight instruction on reset with no register write, and SHALL assert in_ready in the first cycle after reset deassertion.

Structure
REQ-037 SHALL place the opcode constants and the FSM state encoding in shared package exec_pkg.
REQ-038 SHALL implement the ALU, overflow, and zero logic as a combinational sub-module exec_alu parameterised by DATA_W.
REQ-039 SHALL implement the register file inside exec_stage with an asynchronous read and a synchronous write.

Verification
REQ-040 Bench SHALL cover: ADDI instr=0x8105, then ADD 0x0211 -> r1=0x0005, r2=0x000A, out_valid exactly 3 cycles after each accept.
REQ-041 Bench SHALL cover: r1=5, SLL 0x5311 -> result=0x00A0; SRA with r1=0x8000, r2=4 -> 0xF800.
REQ-042 Bench SHALL cover: AUIPC 0xA5FE with pc_in=0x0100 -> r5=0x00FE, ovf=0.
REQ-043 Bench SHALL cover: opcode 0xF -> err=1, result=0, and every register unchanged (checked via dbg_data).
REQ-044 Bench SHALL cover: out_ready held low 4 cycles in DONE -> out_valid and fields stable, in_ready=0, single writeback on release.
REQ-045 Bench SHALL cover: reset pulse in EXEC -> out_valid=0, all registers 0, in_ready=1 the next cycle.
